// File: rtl/ro_puf_ctrl.sv
// Ring-oscillator PUF controller: measures NBITS RO pairs, one response bit each.
// Optional RO_PUF_CTRL_TIE_FLAG_EN adds a sticky 'tie' flag for equal counts.
module ro_puf_ctrl #(
    parameter int SIZE   = 32,
    parameter int WINDOW = 1024,
    parameter int NBITS  = 8,
    localparam int PW    = (NBITS > 1) ? $clog2(NBITS) : 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [SIZE-1:0]  cnt_a,
    input  logic [SIZE-1:0]  cnt_b,
    output logic [PW-1:0]    pair_sel,
    output logic             ro_en,
    output logic             cnt_reset,
    output logic             cnt_en,
    output logic             busy,
    output logic             done,
    output logic [NBITS-1:0] response
`ifdef RO_PUF_CTRL_TIE_FLAG_EN
    ,
    output logic             tie
`endif
);

    localparam int WW = $clog2(WINDOW + 1);
    localparam logic [WW-1:0] WIN_LAST  = WW'(WINDOW - 1);
    localparam logic [WW-1:0] SETL_LAST = WW'(1);
    localparam logic [PW-1:0] PAIR_LAST = PW'(NBITS - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_CLR,
        S_COUNT,
        S_SETTLE,
        S_CMP,
        S_DONE
    } state_t;

    state_t           state_q, state_d;
    logic [WW-1:0]    wcnt_q, wcnt_d;
    logic [PW-1:0]    pair_q, pair_d;
    logic [NBITS-1:0] resp_q, resp_d;
    logic             tie_q, tie_d;
    logic             ro_en_q, ro_en_d;
    logic             cnt_reset_q, cnt_reset_d;
    logic             cnt_en_q, cnt_en_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;

    always_comb begin
        state_d = state_q;
        wcnt_d  = wcnt_q;
        pair_d  = pair_q;
        resp_d  = resp_q;
        tie_d   = tie_q;
        unique case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d = S_CLR;
                    pair_d  = '0;
                    resp_d  = '0;
                    tie_d   = 1'b0;
                end
            end
            S_CLR: begin
                state_d = S_COUNT;
                wcnt_d  = '0;
            end
            S_COUNT: begin
                if (wcnt_q == WIN_LAST) begin
                    state_d = S_SETTLE;
                    wcnt_d  = '0;
                end else begin
                    wcnt_d = wcnt_q + 1'b1;
                end
            end
            // The window counter is reused to time the two settle cycles.
            S_SETTLE: begin
                if (wcnt_q == SETL_LAST) begin
                    state_d = S_CMP;
                    wcnt_d  = '0;
                end else begin
                    wcnt_d = wcnt_q + 1'b1;
                end
            end
            S_CMP: begin
                for (int i = 0; i < NBITS; i++) begin
                    if (pair_q == PW'(i)) begin
                        resp_d[i] = (cnt_a > cnt_b);
                    end
                end
                if (cnt_a == cnt_b) begin
                    tie_d = 1'b1;
                end
                if (pair_q == PAIR_LAST) begin
                    state_d = S_DONE;
                end else begin
                    pair_d  = pair_q + 1'b1;
                    state_d = S_CLR;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // Outputs are decoded from the next state so they register in step with it.
    always_comb begin
        ro_en_d     = (state_d == S_COUNT);
        cnt_en_d    = (state_d == S_COUNT);
        cnt_reset_d = (state_d == S_CLR);
        busy_d      = (state_d != S_IDLE);
        done_d      = (state_d == S_DONE);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= S_IDLE;
            wcnt_q      <= '0;
            pair_q      <= '0;
            resp_q      <= '0;
            tie_q       <= 1'b0;
            ro_en_q     <= 1'b0;
            cnt_reset_q <= 1'b0;
            cnt_en_q    <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            wcnt_q      <= wcnt_d;
            pair_q      <= pair_d;
            resp_q      <= resp_d;
            tie_q       <= tie_d;
            ro_en_q     <= ro_en_d;
            cnt_reset_q <= cnt_reset_d;
            cnt_en_q    <= cnt_en_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
        end
    end

    assign pair_sel  = pair_q;
    assign ro_en     = ro_en_q;
    assign cnt_reset = cnt_reset_q;
    assign cnt_en    = cnt_en_q;
    assign busy      = busy_q;
    assign done      = done_q;
    assign response  = resp_q;

`ifdef RO_PUF_CTRL_TIE_FLAG_EN
    assign tie = tie_q;
`else
    logic unused_tie;
    assign unused_tie = tie_q;
`endif

endmodule

// File: tb/tb_ro_puf_ctrl.sv
// Self-checking bench for ro_puf_ctrl: timeline model plus directed runs.
module tb_ro_puf_ctrl;

    localparam int W = 16;
    localparam int N = 4;
    localparam int P = W + 4;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        start = 1'b0;
    logic [31:0] ta [4];
    logic [31:0] tbv[4];
    logic [31:0] cnt_a, cnt_b;
    logic [1:0]  pair_sel;
    logic        ro_en, cnt_reset, cnt_en, busy, done;
    logic [3:0]  response;
    logic        tie;

    logic        start_s = 1'b0;
    logic [31:0] cnt_a_s, cnt_b_s;
    logic [0:0]  pair_sel_s;
    logic        ro_en_s, cnt_reset_s, cnt_en_s, busy_s, done_s;
    logic [0:0]  response_s;
    logic        tie_s;

    int errors = 0;
    int checks = 0;

    assign cnt_a   = ta[pair_sel];
    assign cnt_b   = tbv[pair_sel];
    assign cnt_a_s = 32'd3;
    assign cnt_b_s = 32'd1;

    ro_puf_ctrl #(.SIZE(32), .WINDOW(W), .NBITS(N)) dut (
        .clk(clk), .reset(reset), .start(start),
        .cnt_a(cnt_a), .cnt_b(cnt_b), .pair_sel(pair_sel),
        .ro_en(ro_en), .cnt_reset(cnt_reset), .cnt_en(cnt_en),
        .busy(busy), .done(done), .response(response)
`ifdef RO_PUF_CTRL_TIE_FLAG_EN
        , .tie(tie)
`endif
    );

    ro_puf_ctrl #(.SIZE(32), .WINDOW(1), .NBITS(1)) dut_s (
        .clk(clk), .reset(reset), .start(start_s),
        .cnt_a(cnt_a_s), .cnt_b(cnt_b_s), .pair_sel(pair_sel_s),
        .ro_en(ro_en_s), .cnt_reset(cnt_reset_s), .cnt_en(cnt_en_s),
        .busy(busy_s), .done(done_s), .response(response_s)
`ifdef RO_PUF_CTRL_TIE_FLAG_EN
        , .tie(tie_s)
`endif
    );

`ifndef RO_PUF_CTRL_TIE_FLAG_EN
    assign tie   = 1'b0;
    assign tie_s = 1'b0;
`endif

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h at %0t", nm, act, exp, $time);
        end
    endtask

    function automatic logic [3:0] full_resp();
        logic [3:0] r;
        for (int p = 0; p < N; p++) r[p] = (ta[p] > tbv[p]);
        return r;
    endfunction

    function automatic logic full_tie();
        logic t = 1'b0;
        for (int p = 0; p < N; p++) t |= (ta[p] == tbv[p]);
        return t;
    endfunction

    // Model: a run is a timeline of N*P steps after the accepted start, then DONE.
    bit         m_act = 0;
    int         m_t = 0;
    logic [3:0] m_resp_hold = '0;
    logic [1:0] m_pair_hold = '0;
    logic       m_tie_hold = 1'b0;

    always @(posedge clk) begin
        if (reset) begin
            m_act = 0;
            m_resp_hold = '0;
            m_pair_hold = '0;
            m_tie_hold = 1'b0;
        end else if (!m_act) begin
            if (start) begin
                m_act = 1;
                m_t = 0;
            end
        end else if (m_t == N * P) begin
            m_act = 0;
        end else begin
            m_t++;
            if (m_t == N * P) begin
                m_resp_hold = full_resp();
                m_pair_hold = 2'(N - 1);
                m_tie_hold  = full_tie();
            end
        end
    end

    always @(negedge clk) begin
        logic [1:0] e_pair;
        logic [3:0] e_resp;
        logic e_busy, e_done, e_clr, e_en, e_tie;
        int pr, ph;
        e_pair = m_pair_hold;
        e_resp = m_resp_hold;
        e_tie  = m_tie_hold;
        e_busy = 0; e_done = 0; e_clr = 0; e_en = 0;
        if (m_act) begin
            e_busy = 1;
            if (m_t == N * P) begin
                e_done = 1;
            end else begin
                pr = m_t / P;
                ph = m_t % P;
                e_pair = 2'(pr);
                e_clr  = (ph == 0);
                e_en   = (ph >= 1 && ph <= W);
                e_resp = '0;
                e_tie  = 1'b0;
                for (int p = 0; p < pr; p++) begin
                    e_resp[p] = (ta[p] > tbv[p]);
                    e_tie |= (ta[p] == tbv[p]);
                end
            end
        end
        chk("pair_sel", 32'(pair_sel), 32'(e_pair));
        chk("ro_en", 32'(ro_en), 32'(e_en));
        chk("cnt_en", 32'(cnt_en), 32'(e_en));
        chk("cnt_reset", 32'(cnt_reset), 32'(e_clr));
        chk("busy", 32'(busy), 32'(e_busy));
        chk("done", 32'(done), 32'(e_done));
        chk("response", 32'(response), 32'(e_resp));
`ifdef RO_PUF_CTRL_TIE_FLAG_EN
        chk("tie", 32'(tie), 32'(e_tie));
`endif
    end

    task automatic step(input int n);
        repeat (n) begin
            @(negedge clk);
            #1;
        end
    endtask

    task automatic set_tab(input logic [31:0] a0, b0, a1, b1, a2, b2, a3, b3);
        ta[0] = a0; tbv[0] = b0; ta[1] = a1; tbv[1] = b1;
        ta[2] = a2; tbv[2] = b2; ta[3] = a3; tbv[3] = b3;
    endtask

    // Waits for done; n is the number of edges after the sampling edge.
    task automatic wait_done(output int n, output int nclr, output int nen,
                             output logic [7:0] seq);
        bit seen = 0;
        n = 0; nclr = 0; nen = 0; seq = '0;
        if (cnt_reset) begin nclr++; seq = {seq[5:0], pair_sel}; end
        while (n < 300 && !seen) begin
            step(1);
            n++;
            if (cnt_reset) begin nclr++; seq = {seq[5:0], pair_sel}; end
            if (cnt_en && ro_en) nen++;
            if (done) seen = 1;
        end
        if (!seen) chk("done_timeout", 32'(n), 32'd80);
    endtask

    int         n, nclr, nen, cnt;
    logic [7:0] seq;

    initial begin
        set_tab(32'd20, 32'd10, 32'd5, 32'd9, 32'd30, 32'd29, 32'd7, 32'd7);
        step(3);
        chk("rst_pair_sel", 32'(pair_sel), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_response", 32'(response), 32'd0);
        chk("rst_cnt_reset", 32'(cnt_reset), 32'd0);
        reset = 1'b0;
        step(2);

        // Run 1: reference pattern
        start = 1'b1;
        step(1);
        start = 1'b0;
        wait_done(n, nclr, nen, seq);
        chk("run1_latency", 32'(n), 32'd80);
        chk("run1_response", 32'(response), 32'b0101);
        chk("run1_clr_cycles", 32'(nclr), 32'd4);
        chk("run1_en_cycles", 32'(nen), 32'd64);
        chk("run1_pair_seq", 32'(seq), 32'h1B);
`ifdef RO_PUF_CTRL_TIE_FLAG_EN
        chk("run1_tie", 32'(tie), 32'd1);
`endif
        step(1);
        chk("idle_busy", 32'(busy), 32'd0);
        chk("idle_hold_resp", 32'(response), 32'b0101);

        // Run 2: start held across DONE, then restarted while busy
        start = 1'b1;
        step(1);
        start = 1'b0;
        n = 0;
        while (n < 300 && !done) begin step(1); n++; end
        start = 1'b1;
        step(2);
        start = 1'b0;
        chk("restart_after_done", 32'(cnt_reset), 32'd1);
        cnt = 0;
        n = 0;
        while (n < 120) begin
            step(1);
            n++;
            if (n >= 10 && n < 14) start = 1'b1;
            else start = 1'b0;
            if (done) begin
                cnt++;
                if (cnt == 1) chk("run2_latency", 32'(n), 32'd80);
            end
        end
        chk("run2_done_once", 32'(cnt), 32'd1);

        // Reset during COUNT of pair 2
        start = 1'b1;
        step(1);
        start = 1'b0;
        n = 0;
        while (n < 300 && !(pair_sel == 2'd2 && cnt_en)) begin step(1); n++; end
        chk("reach_pair2", 32'(pair_sel), 32'd2);
        step(3);
        reset = 1'b1;
        #1;
        chk("abort_ro_en", 32'(ro_en), 32'd0);
        chk("abort_cnt_en", 32'(cnt_en), 32'd0);
        chk("abort_busy", 32'(busy), 32'd0);
        chk("abort_response", 32'(response), 32'd0);
        chk("abort_pair_sel", 32'(pair_sel), 32'd0);
        step(3);
        reset = 1'b0;
        cnt = 0;
        repeat (100) begin step(1); if (done) cnt++; end
        chk("abort_no_done", 32'(cnt), 32'd0);
        start = 1'b1;
        step(1);
        start = 1'b0;
        wait_done(n, nclr, nen, seq);
        chk("post_abort_latency", 32'(n), 32'd80);
        chk("post_abort_resp", 32'(response), 32'b0101);
        chk("post_abort_pairs", 32'(seq), 32'h1B);
        step(2);

        // Extreme counts
        set_tab(32'hFFFFFFFF, 0, 32'hFFFFFFFF, 0, 32'hFFFFFFFF, 0, 32'hFFFFFFFF, 0);
        start = 1'b1;
        step(1);
        start = 1'b0;
        wait_done(n, nclr, nen, seq);
        chk("max_resp", 32'(response), 32'b1111);
`ifdef RO_PUF_CTRL_TIE_FLAG_EN
        chk("max_tie", 32'(tie), 32'd0);
`endif
        step(2);
        set_tab(0, 32'hFFFFFFFF, 0, 32'hFFFFFFFF, 0, 32'hFFFFFFFF, 0, 32'hFFFFFFFF);
        start = 1'b1;
        step(1);
        start = 1'b0;
        wait_done(n, nclr, nen, seq);
        chk("swap_resp", 32'(response), 32'b0000);
        step(2);

        // NBITS=1, WINDOW=1 instance
        start_s = 1'b1;
        step(1);
        start_s = 1'b0;
        cnt = 0;
        n = 0;
        if (pair_sel_s != 1'b0) cnt++;
        while (n < 50 && !done_s) begin
            step(1);
            n++;
            if (pair_sel_s != 1'b0) cnt++;
        end
        chk("small_latency", 32'(n), 32'd5);
        chk("small_pair_sel", 32'(cnt), 32'd0);
        chk("small_response", 32'(response_s), 32'd1);
        step(1);
        chk("small_idle", 32'(busy_s), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/ro_puf_ctrl.md
RO_PUF_CTRL -- requirements
Module: ro_puf_ctrl

Interface
REQ-001 Parameter SIZE, default 32, width of the measured counter values.
REQ-002 Parameter WINDOW, default 1024, measurement window length in clk cycles (range 1 to 2^20).
REQ-003 Parameter NBITS, default 8, response bits per run, i.e. number of RO pairs (range 1 to 64).
REQ-004 clk  input  1  single system clock; all state changes on its rising edge.
REQ-005 reset  input  1  asynchronous, active-high reset.
REQ-006 start  input  1  run request; sampled only in IDLE.
REQ-007 cnt_a  input  SIZE  count of RO A of the selected pair.
REQ-008 cnt_b  input  SIZE  count of RO B of the selected pair.
REQ-009 pair_sel  output  clog2(NBITS) (minimum 1)  index of the RO pair under measurement.
REQ-010 ro_en  output  1  enables the selected ring oscillators.
REQ-011 cnt_reset  output  1  clears both pair counters.
REQ-012 cnt_en  output  1  enables both pair counters.
REQ-013 busy  output  1  high whenever state is not IDLE.
REQ-014 done  output  1  one-cycle pulse at run completion.
REQ-015 response  output  NBITS  PUF response word.

Function
REQ-016 The FSM SHALL have states IDLE, CLR, COUNT, SETTLE, CMP and DONE.
REQ-017 IDLE: all control outputs low; start=1 moves to CLR with pair_sel=0 and response cleared to 0.
REQ-018 CLR (1 cycle): cnt_reset=1, ro_en=0, cnt_en=0; then moves to COUNT.
REQ-019 COUNT (exactly WINDOW cycles, tracked by an internal window counter): ro_en=1, cnt_en=1, cnt_reset=0; then moves to SETTLE.
REQ-020 SETTLE (exactly 2 cycles): ro_en=0, cnt_en=0, so counter values are stable before comparison.
REQ-021 CMP (1 cycle): response[pair_sel] is set to 1 if cnt_a > cnt_b (unsigned compare), else 0.
REQ-022 CMP exit: if pair_sel = NBITS-1, move to DONE; otherwise increment pair_sel and move to CLR.
REQ-023 DONE (1 cycle): done=1; then moves to IDLE; response holds its value until the next accepted start.
REQ-024 Per-bit latency SHALL be WINDOW+4 cycles; done SHALL assert exactly NBITS*(WINDOW+4) cycles after the cycle in which start is sampled.
REQ-025 start asserted in any state other than IDLE SHALL be ignored; start held high in the DONE cycle is not sampled, and a start sampled in IDLE immediately after DONE begins a new run.
REQ-026 Equal counts (cnt_a = cnt_b) SHALL yield response bit 0.
REQ-027 pair_sel SHALL never exceed NBITS-1 and SHALL hold its value outside CMP transitions.

Reset
REQ-028 While reset=1, the block SHALL asynchronously force: state IDLE, pair_sel=0, response=0, window counter=0, and all single-bit outputs to 0.
REQ-029 Reset asserted mid-run SHALL abort the run with no done pulse; the first start sampled after release begins a fresh run from pair 0.

Configuration
REQ-030 Macro RO_PUF_CTRL_TIE_FLAG_EN SHALL, when defined, add output port tie (1 bit).
REQ-031 With RO_PUF_CTRL_TIE_FLAG_EN defined, tie is cleared at start acceptance, set in any CMP cycle where cnt_a = cnt_b, held through DONE, and reset to 0.
REQ-032 Without RO_PUF_CTRL_TIE_FLAG_EN, the tie port and its logic are absent; all other behaviour is identical.

Verification
REQ-033 WINDOW=16, NBITS=4, bench counters model cnt_a/cnt_b per pair = (20,10),(5,9),(30,29),(7,7); pulse start -> response=4'b0101, done pulse exactly 80 cycles after start sampled; tie=1 if TIE_FLAG_EN defined.
REQ-034 Check output timing per pair -> cnt_reset high 1 cycle, cnt_en/ro_en high exactly 16 cycles, 2 idle cycles, then compare; pair_sel steps 0,1,2,3.
REQ-035 Pulse start again while busy=1 -> no restart; done fires once; run length unchanged.
REQ-036 Assert reset during COUNT of pair 2 -> outputs 0, response=0 immediately; no done; next start completes a full 4-pair run.
REQ-037 cnt_a=32'hFFFFFFFF, cnt_b=32'h00000000 on all pairs -> response=4'b1111; swap the values -> response=4'b0000.
REQ-038 NBITS=1, WINDOW=1 -> done pulse 5 cycles after start sampled; pair_sel stays 0 throughout.
